ysyx_22050243_lsu: RTL and testbench
====================================

# ysyx_22050243_lsu

Multi-cycle load/store unit. Consumes the decoder's `mem_r`/`mem_w` strobes, `funct3`, the ALU-computed address and rs2 data, and runs one transaction on the 64-bit data bus. It returns sign- or zero-extended load data, a store completion, or a misalignment/illegal error to the register-writeback path. It sits between execute and writeback in the RV64 NPC core.

## Interface
- No parameters. XLEN is fixed at 64; the bus is 64 bits wide with byte strobes.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request from execute; meaningful only when `mem_r` or `mem_w` is set.
- `in_ready` out 1: unit can accept a request.
- `mem_r` in 1: load request.
- `mem_w` in 1: store request.
- `funct3` in 3: access size and sign-extension selector.
- `addr` in 64: effective byte address.
- `wdata` in 64: store data, taken from rs2 and right-justified.
- `out_valid` out 1: one-cycle completion pulse.
- `out_rdata` out 64: extended load data; 0 for stores and errors.
- `out_err` out 1: misaligned or illegal access; qualified by `out_valid`.
- `dbus_req` out 1: bus request, held until granted.
- `dbus_we` out 1: 1 = write.
- `dbus_addr` out 64: `addr` with bits [2:0] forced to 0.
- `dbus_wdata` out 64: store data shifted into its byte lanes.
- `dbus_wstrb` out 8: byte enables; 0 on reads.
- `dbus_gnt` in 1: request accepted in this cycle.
- `dbus_rvalid` in 1: read data valid; arrives no earlier than the cycle after `dbus_gnt`.
- `dbus_rdata` in 64: aligned doubleword of read data.

## Operation
- **`funct3` encoding:**
  - 000 = b, 001 = h, 010 = w, 011 = d.
  - 100 = bu, 101 = hu, 110 = wu; these are load-only.
  - 111, and stores with `funct3[2]` set, are illegal.
- **Request acceptance:** a request is accepted on `in_valid && in_ready`. All inputs are registered at that edge, so the inputs may change afterwards.
- **Error check at acceptance:** the access is an error if any of the following holds:
  - `mem_r` and `mem_w` are both set;
  - `funct3` is illegal;
  - the address is misaligned: h needs `addr[0]`=0, w needs `addr[1:0]`=0, d needs `addr[2:0]`=0.
  - An error access issues no bus request.
- **Request dropped:** `in_valid` with neither `mem_r` nor `mem_w` set is ignored (no state change).
- **Store lane mapping:** with `off` = `addr[2:0]`:
  - `dbus_wdata` = `wdata` << 8·`off`.
  - `dbus_wstrb` = 1, 3, F or FF hex for b/h/w/d, shifted left by `off`.
- **Load extraction:** the selected bytes are `dbus_rdata` >> 8·`off`, truncated to the access size. They are sign-extended for b/h/w and zero-extended for bu/hu/wu/d.
- **State machine:**
  - **IDLE:** `in_ready`=1.
    - Accept with error → ERR.
    - Accept without error → REQ.
  - **REQ:** `dbus_req`=1, and `dbus_we`/`dbus_addr`/`dbus_wdata`/`dbus_wstrb` are held stable.
    - On `dbus_gnt`: a store goes to RESP; a load goes to WAIT.
  - **WAIT:** on `dbus_rvalid`, capture the extracted data → RESP.
  - **ERR:** `out_valid`=1, `out_err`=1, `out_rdata`=0 → IDLE.
  - **RESP:** `out_valid`=1, `out_err`=0 → IDLE.
- **Stray bus events:** `dbus_gnt` or `dbus_rvalid` seen outside REQ or WAIT is ignored.

## Timing
- **Reset:** while `rst` is high and on the cycle it falls, the state is IDLE. Output values during and after reset:
  - `in_ready`=0 while `rst`=1, and 1 afterwards.
  - All other outputs are 0.
- **Latency, counted from the accept edge (cycle 0) with an immediate grant:**
  - Store: `dbus_req` in cycle 1, `out_valid` in cycle 2.
  - Load: `dbus_req` in cycle 1, earliest `dbus_rvalid` in cycle 2, `out_valid` in cycle 3.
  - Error: `out_valid` in cycle 1.
- **Bus stalls:** each cycle without `dbus_gnt` or `dbus_rvalid` adds one cycle of latency. There is no timeout.
- **Request rate:** `in_ready` is low from the cycle after acceptance until the cycle after `out_valid`, so there is at most one outstanding request. Back-to-back stores therefore complete every 3 cycles at best.
- **Completion pulse:** `out_valid` is high for exactly one cycle. The consumer must not stall it.
- **Reset mid-transaction:** the transaction is abandoned. `dbus_req` is low in the cycle after `rst` is sampled, and a later `rvalid` is ignored.

## Structure
- **Package `ysyx_22050243_lsu_pkg`:**
  - `funct3` localparams: `LSU_B` … `LSU_WU`.
  - State enum `lsu_state_t`: IDLE, REQ, WAIT, ERR, RESP.
  - The package is shared with writeback and the testbench.
- **Sub-module `ysyx_22050243_lsu_align`:** combinational. It generates the store lane shift and strobes, and performs load extraction and extension. It is instantiated once in the top-level FSM.

## Test plan
- **Aligned loads:** load lw at 0x8000_0004 with `dbus_rdata`=0x8000_0001_1234_5678, granted in cycle 1 with `rvalid` in cycle 2 → `dbus_wstrb`=0, `out_rdata`=0xFFFF_FFFF_8000_0001 at cycle 3. Repeat with lwu → 0x0000_0000_8000_0001.
- **Byte store:** sb at 0x8000_0003 with `wdata`=0xAB → `dbus_addr`=0x8000_0000, `dbus_wstrb`=0x08, `dbus_wdata`[31:24]=0xAB, `out_valid` at cycle 2.
- **Misaligned access:** lh at 0x8000_0001 → no `dbus_req`, `out_valid`=`out_err`=1 at cycle 1, `out_rdata`=0. Store with `funct3`=110 gives the same response.
- **Grant stall:** hold `dbus_gnt`=0 for 4 cycles on sd → `dbus_req` and all bus fields stay stable, `in_ready`=0, and `out_valid` follows the grant by 1 cycle.
- **Reset mid-load:** assert `rst` in WAIT, then pulse `rvalid` after release → no `out_valid`, `in_ready`=1.
- **Sweep:** all legal `funct3`/offset combinations against a reference model, with random gnt/rvalid delays of 0–5 cycles.

Source files
------------

// File: rtl/ysyx_22050243_lsu_pkg.sv
// ysyx_22050243_lsu_pkg
// Definitions shared by the load/store unit, writeback and the testbench:
//   - funct3 access encodings LSU_B .. LSU_WU
//   - lsu_state_t, the FSM state encoding of the LSU
//   - lsu_access_err(), the legality/alignment check applied at acceptance
package ysyx_22050243_lsu_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ERR,
        RESP
    } lsu_state_t;

    // An access is rejected when it is both a load and a store, uses the
    // reserved encoding, asks for a zero-extending store, or is not
    // naturally aligned to its size (funct3[1:0] is log2 of the size).
    function automatic logic lsu_access_err(
        input logic       mem_r,
        input logic       mem_w,
        input logic [2:0] funct3,
        input logic [2:0] off
    );
        logic illegal;
        logic misaligned;
        illegal = (funct3 == 3'b111) || (mem_w && funct3[2]);
        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
        return (mem_r && mem_w) || illegal || misaligned;
    endfunction

endpackage

// File: rtl/ysyx_22050243_lsu_align.sv
// ysyx_22050243_lsu_align
// Combinational byte-lane steering for the LSU.
//   off_i     byte offset of the access inside the doubleword
//   funct3_i  access size / extension selector
//   wdata_i   right-justified store data
//   rdata_i   aligned doubleword returned by the bus
//   wdata_o   store data moved into its byte lanes
//   wstrb_o   byte enables for a store of this size and offset
//   rdata_o   selected load bytes, sign- or zero-extended to 64 bits
module ysyx_22050243_lsu_align
    import ysyx_22050243_lsu_pkg::*;
(
    input  logic [2:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [63:0] wdata_o,
    output logic [7:0]  wstrb_o,
    output logic [63:0] rdata_o
);

    logic [5:0]  sh_amt;
    logic [7:0]  strb_base;
    logic [63:0] rsh;

    function automatic logic [63:0] ext_b(input logic [7:0] v, input logic uns);
        logic signed [7:0]  s;
        logic signed [63:0] r;
        s = v;
        r = s;
        return uns ? {56'd0, v} : r;
    endfunction

    function automatic logic [63:0] ext_h(input logic [15:0] v, input logic uns);
        logic signed [15:0] s;
        logic signed [63:0] r;
        s = v;
        r = s;
        return uns ? {48'd0, v} : r;
    endfunction

    function automatic logic [63:0] ext_w(input logic [31:0] v, input logic uns);
        logic signed [31:0] s;
        logic signed [63:0] r;
        s = v;
        r = s;
        return uns ? {32'd0, v} : r;
    endfunction

    assign sh_amt = {off_i, 3'b000};

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   strb_base = 8'h01;
            2'b01:   strb_base = 8'h03;
            2'b10:   strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    end

    assign wstrb_o = strb_base << off_i;
    assign wdata_o = wdata_i << sh_amt;
    assign rsh     = rdata_i >> sh_amt;

    always_comb begin
        case (funct3_i)
            LSU_B:   rdata_o = ext_b(rsh[7:0], 1'b0);
            LSU_BU:  rdata_o = ext_b(rsh[7:0], 1'b1);
            LSU_H:   rdata_o = ext_h(rsh[15:0], 1'b0);
            LSU_HU:  rdata_o = ext_h(rsh[15:0], 1'b1);
            LSU_W:   rdata_o = ext_w(rsh[31:0], 1'b0);
            LSU_WU:  rdata_o = ext_w(rsh[31:0], 1'b1);
            default: rdata_o = rsh;
        endcase
    end

endmodule

// File: rtl/ysyx_22050243_lsu.sv
// ysyx_22050243_lsu
// Multi-cycle load/store unit between execute and writeback. Accepts one
// request at a time, runs a single transaction on the 64-bit data bus and
// returns extended load data, a store completion, or an error.
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            request handshake from execute
//   mem_r, mem_w, funct3         load/store strobes and access selector
//   addr, wdata                  effective address, right-justified store data
//   out_valid/out_rdata/out_err  one-cycle completion to writeback
//   dbus_req/we/addr/wdata/wstrb bus request, held until dbus_gnt
//   dbus_gnt, dbus_rvalid, dbus_rdata  bus grant and read return
module ysyx_22050243_lsu
    import ysyx_22050243_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        out_valid,
    output logic [63:0] out_rdata,
    output logic        out_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [63:0] dbus_addr,
    output logic [63:0] dbus_wdata,
    output logic [7:0]  dbus_wstrb,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [63:0] dbus_rdata
);

    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;

    logic        accept;
    logic        acc_err;
    logic [63:0] lane_wdata;
    logic [7:0]  lane_wstrb;
    logic [63:0] lane_rdata;

    // in_ready is masked by rst so nothing is accepted while reset is held,
    // even in the first cycle before the state register has been cleared.
    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready && (mem_r || mem_w);
    assign acc_err  = lsu_access_err(mem_r, mem_w, funct3, addr[2:0]);

    ysyx_22050243_lsu_align u_align (
        .off_i    (addr_q[2:0]),
        .funct3_i (funct3_q),
        .wdata_i  (wdata_q),
        .rdata_i  (dbus_rdata),
        .wdata_o  (lane_wdata),
        .wstrb_o  (lane_wstrb),
        .rdata_o  (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are captured at acceptance so execute may move on;
    // load data is captured already extended when the bus returns it.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= mem_w;
            funct3_q <= funct3;
            addr_q   <= addr;
            wdata_q  <= wdata;
        end
        if (state_q == WAIT && dbus_rvalid) begin
            rdata_q <= lane_rdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_valid  = 1'b0;
        out_err    = 1'b0;
        out_rdata  = 64'd0;
        dbus_req   = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = 64'd0;
        dbus_wdata = 64'd0;
        dbus_wstrb = 8'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = acc_err ? ERR : REQ;
                end
            end
            REQ: begin
                dbus_req   = 1'b1;
                dbus_we    = we_q;
                dbus_addr  = {addr_q[63:3], 3'b000};
                dbus_wdata = we_q ? lane_wdata : 64'd0;
                dbus_wstrb = we_q ? lane_wstrb : 8'd0;
                if (dbus_gnt) begin
                    state_d = we_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (dbus_rvalid) begin
                    state_d = RESP;
                end
            end
            ERR: begin
                out_valid = 1'b1;
                out_err   = 1'b1;
                state_d   = IDLE;
            end
            RESP: begin
                out_valid = 1'b1;
                out_rdata = we_q ? 64'd0 : rdata_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
module tb_ysyx_22050243_lsu;
    import ysyx_22050243_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mem_r;
    logic        mem_w;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        out_valid;
    logic [63:0] out_rdata;
    logic        out_err;
    logic        dbus_req;
    logic        dbus_we;
    logic [63:0] dbus_addr;
    logic [63:0] dbus_wdata;
    logic [7:0]  dbus_wstrb;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [63:0] dbus_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22050243_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_r       (mem_r),
        .mem_w       (mem_w),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .out_valid   (out_valid),
        .out_rdata   (out_rdata),
        .out_err     (out_err),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_wdata  (dbus_wdata),
        .dbus_wstrb  (dbus_wstrb),
        .dbus_gnt    (dbus_gnt),
        .dbus_rvalid (dbus_rvalid),
        .dbus_rdata  (dbus_rdata)
    );

    // ---------------- reference model ----------------
    function automatic int acc_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_err(input logic r, input logic w,
                                       input logic [2:0] f3, input logic [63:0] a);
        if (r && w) return 1'b1;
        if (f3 == 3'b111) return 1'b1;
        if (w && f3 >= 3'd4) return 1'b1;
        if ((int'(a[2:0]) % acc_bytes(f3)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] model_strb(input logic [2:0] f3, input int off);
        logic [15:0] s;
        s = ((16'd1 << acc_bytes(f3)) - 16'd1) << off;
        return s[7:0];
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input int off,
                                               input logic [63:0] rd);
        logic [63:0] v;
        logic [63:0] mask;
        int n;
        n = acc_bytes(f3);
        v = rd >> (8 * off);
        mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        v = v & mask;
        if (f3 < 3'd3 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        mem_r  = 1'($urandom);
        mem_w  = 1'($urandom);
        funct3 = 3'($urandom);
        addr   = {$urandom, $urandom};
        wdata  = {$urandom, $urandom};
    endtask

    // Runs one request from the current cycle (cycle 0 = accept cycle) and
    // acts as the bus. Returns the observed rdata, latency and done cycle.
    task automatic run_txn(input logic r, input logic w, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] rd, input int gdly, input int rdly,
                           output logic [63:0] got, output int lat, output int done_cyc);
        logic        exp_err;
        logic [63:0] exp_addr;
        logic [63:0] exp_wd;
        logic [7:0]  exp_strb;
        logic [63:0] exp_rd;
        int          off;
        int          start;
        off      = int'(a[2:0]);
        exp_err  = model_err(r, w, f3, a);
        exp_addr = a - 64'(off);
        exp_wd   = wd << (8 * off);
        exp_strb = w ? model_strb(f3, off) : 8'h00;
        exp_rd   = w ? 64'd0 : model_load(f3, off, rd);
        start    = cyc;

        in_valid = 1'b1; mem_r = r; mem_w = w; funct3 = f3; addr = a; wdata = wd;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL accept_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        scramble_inputs();

        if (exp_err) begin
            n_checks++;
            if ({out_valid, out_err, out_rdata, dbus_req} !== {1'b1, 1'b1, 64'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL err_resp: got vld=%b err=%b rdata=%h req=%b expected 1 1 0 0",
                         out_valid, out_err, out_rdata, dbus_req);
            end
        end else begin
            for (int k = 0; k <= gdly; k++) begin
                n_checks++;
                if ({dbus_req, dbus_we, dbus_addr, dbus_wstrb, in_ready, out_valid} !==
                    {1'b1, w, exp_addr, exp_strb, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL req_phase: got req=%b we=%b addr=%h strb=%h rdy=%b vld=%b expected 1 %b %h %h 0 0",
                             dbus_req, dbus_we, dbus_addr, dbus_wstrb, in_ready, out_valid,
                             w, exp_addr, exp_strb);
                end
                if (w) begin
                    n_checks++;
                    if (dbus_wdata !== exp_wd) begin
                        n_fail++;
                        $display("FAIL req_wdata: got %h expected %h", dbus_wdata, exp_wd);
                    end
                end
                dbus_gnt   = (k == gdly);
                dbus_rdata = {$urandom, $urandom};
                step();
            end
            dbus_gnt = 1'b0;
            if (!w) begin
                for (int k = 0; k <= rdly; k++) begin
                    n_checks++;
                    if ({dbus_req, out_valid, in_ready} !== 3'b000) begin
                        n_fail++;
                        $display("FAIL wait_phase: got req=%b vld=%b rdy=%b expected 0 0 0",
                                 dbus_req, out_valid, in_ready);
                    end
                    dbus_gnt    = 1'($urandom);
                    dbus_rvalid = (k == rdly);
                    dbus_rdata  = (k == rdly) ? rd : {$urandom, $urandom};
                    step();
                end
                dbus_gnt    = 1'b0;
                dbus_rvalid = 1'b0;
                dbus_rdata  = {$urandom, $urandom};
            end
            n_checks++;
            if ({out_valid, out_err, in_ready, dbus_req, out_rdata} !== {4'b1000, exp_rd}) begin
                n_fail++;
                $display("FAIL resp: got vld=%b err=%b rdy=%b req=%b rdata=%h expected 1 0 0 0 %h",
                         out_valid, out_err, in_ready, dbus_req, out_rdata, exp_rd);
            end
        end
        got      = out_rdata;
        done_cyc = cyc;
        lat      = cyc - start;
        step();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL after_resp: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; mem_r = 1'b1; mem_w = 1'b0; funct3 = LSU_W;
        addr = 64'h8000_0000; wdata = 64'd0;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 64'd0;
        step();
        step();
        n_checks++;
        if ({in_ready, out_valid, out_err, out_rdata, dbus_req, dbus_we, dbus_addr,
             dbus_wdata, dbus_wstrb} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b req=%b we=%b addr=%h expected all 0",
                     in_ready, out_valid, out_err, dbus_req, dbus_we, dbus_addr);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
        step();
        n_checks++;
        if ({dbus_req, out_valid, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_no_accept: got req=%b vld=%b rdy=%b expected 0 0 1",
                     dbus_req, out_valid, in_ready);
        end
    endtask

    task automatic test_aligned_loads();
        logic [63:0] got;
        int lat, dc;
        run_txn(1'b1, 1'b0, LSU_W, 64'h8000_0004, 64'h0, 64'h8000_0001_1234_5678, 0, 0, got, lat, dc);
        n_checks++;
        if (got !== 64'hFFFF_FFFF_8000_0001 || lat != 3) begin
            n_fail++; $display("FAIL lw: got %h lat %0d expected ffffffff80000001 lat 3", got, lat);
        end
        run_txn(1'b1, 1'b0, LSU_WU, 64'h8000_0004, 64'h0, 64'h8000_0001_1234_5678, 0, 0, got, lat, dc);
        n_checks++;
        if (got !== 64'h0000_0000_8000_0001 || lat != 3) begin
            n_fail++; $display("FAIL lwu: got %h lat %0d expected 0000000080000001 lat 3", got, lat);
        end
    endtask

    task automatic test_byte_store();
        logic [63:0] got;
        int lat, dc;
        run_txn(1'b0, 1'b1, LSU_B, 64'h8000_0003, 64'hAB, 64'h0, 0, 0, got, lat, dc);
        n_checks++;
        if (lat != 2) begin
            n_fail++; $display("FAIL sb_latency: got %0d expected 2", lat);
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] got;
        int lat, dc;
        run_txn(1'b1, 1'b0, LSU_H, 64'h8000_0001, 64'h0, 64'h0, 0, 0, got, lat, dc);
        n_checks++;
        if (lat != 1) begin
            n_fail++; $display("FAIL lh_mis_latency: got %0d expected 1", lat);
        end
        run_txn(1'b0, 1'b1, LSU_WU, 64'h8000_0000, 64'h1234, 64'h0, 0, 0, got, lat, dc);
        n_checks++;
        if (lat != 1) begin
            n_fail++; $display("FAIL swu_illegal_latency: got %0d expected 1", lat);
        end
        run_txn(1'b1, 1'b0, 3'b111, 64'h8000_0000, 64'h0, 64'h0, 0, 0, got, lat, dc);
        run_txn(1'b1, 1'b1, LSU_D, 64'h8000_0000, 64'h0, 64'h0, 0, 0, got, lat, dc);
    endtask

    task automatic test_grant_stall();
        logic [63:0] got;
        int lat, dc;
        run_txn(1'b0, 1'b1, LSU_D, 64'h8000_0008, 64'hDEAD_BEEF_0123_4567, 64'h0, 4, 0, got, lat, dc);
        n_checks++;
        if (lat != 6) begin
            n_fail++; $display("FAIL sd_stall_latency: got %0d expected 6", lat);
        end
    endtask

    task automatic test_reset_mid_load();
        in_valid = 1'b1; mem_r = 1'b1; mem_w = 1'b0; funct3 = LSU_W; addr = 64'h8000_0010;
        step();
        in_valid = 1'b0; mem_r = 1'b0;
        n_checks++;
        if (dbus_req !== 1'b1) begin
            n_fail++; $display("FAIL rml_req: got %b expected 1", dbus_req);
        end
        dbus_gnt = 1'b1;
        step();
        dbus_gnt = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, dbus_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL rml_in_reset: got rdy=%b vld=%b req=%b expected 0 0 0", in_ready, out_valid, dbus_req);
        end
        step();
        rst = 1'b0;
        #1;
        dbus_rvalid = 1'b1; dbus_rdata = {$urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({dbus_req, out_valid, in_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL rml_after_reset: got req=%b vld=%b rdy=%b expected 0 0 1",
                         dbus_req, out_valid, in_ready);
            end
            step();
            dbus_rvalid = 1'b0;
        end
    endtask

    task automatic test_dropped();
        in_valid = 1'b1; mem_r = 1'b0; mem_w = 1'b0; funct3 = LSU_D; addr = 64'h8000_0000;
        dbus_gnt = 1'b1; dbus_rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({dbus_req, out_valid, in_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL dropped: got req=%b vld=%b rdy=%b expected 0 0 1", dbus_req, out_valid, in_ready);
            end
        end
        in_valid = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] got;
        int lat, dc, prev;
        run_txn(1'b0, 1'b1, LSU_W, 64'h8000_0100, 64'h1111_2222, 64'h0, 0, 0, got, lat, prev);
        for (int k = 0; k < 3; k++) begin
            run_txn(1'b0, 1'b1, LSU_H, 64'h8000_0102 + 64'(8 * k), 64'(k + 1), 64'h0, 0, 0, got, lat, dc);
            n_checks++;
            if (dc - prev != 3) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d expected 3", dc - prev);
            end
            prev = dc;
        end
    endtask

    task automatic test_sweep();
        logic [63:0] got;
        logic [63:0] a;
        int lat, dc, g, rv, exp_lat;
        logic w;
        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < 2; s++) begin
                w = (s == 1);
                for (int off = 0; off < 8; off++) begin
                    g  = int'($urandom_range(0, 5));
                    rv = int'($urandom_range(0, 5));
                    a  = {32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom & 32'hFFFF_FFF8} | 64'(off);
                    if (model_err(!w, w, 3'(f), a)) exp_lat = 1;
                    else if (w) exp_lat = 2 + g;
                    else exp_lat = 3 + g + rv;
                    run_txn(!w, w, 3'(f), a, {$urandom, $urandom}, {$urandom, $urandom}, g, rv, got, lat, dc);
                    n_checks++;
                    if (lat != exp_lat) begin
                        n_fail++;
                        $display("FAIL sweep_latency f3=%0d w=%b off=%0d: got %0d expected %0d", f, w, off, lat, exp_lat);
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aligned_loads();
        test_byte_store();
        test_misaligned();
        test_grant_stall();
        test_reset_mid_load();
        test_dropped();
        test_back_to_back();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
